// File: rtl/tarsier_pkg.sv
// Shared tarsier definitions: default keypoint field widths, the keypoint record
// layout and small elaboration helpers used by the coordinate and detector stages.
package tarsier_pkg;

  localparam int KP_COORD_BITS = 16;
  localparam int KP_SCORE_BITS = 8;

  // Record order {x, y, score}, MSB first; lane FIFOs store keypoints packed this way.
  typedef struct packed {
    logic [KP_COORD_BITS-1:0] x;
    logic [KP_COORD_BITS-1:0] y;
    logic [KP_SCORE_BITS-1:0] score;
  } keypoint_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_HELD  = 1'b1
  } out_state_e;

  function automatic int lvl_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/keypoint_merger_fifo.sv
// Per-lane keypoint FIFO; a push into a full FIFO succeeds when it is popped in
// the same cycle, so occupancy stays constant.
module keypoint_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage carries data only; validity is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/keypoint_merger.sv
// Merges per-pyramid-level keypoint streams into one ready/valid stream with
// round-robin lane selection, per-lane buffering and drop accounting.
module keypoint_merger
  import tarsier_pkg::*;
#(
  parameter  int COORD_BITS = KP_COORD_BITS,
  parameter  int SCORE_BITS = KP_SCORE_BITS,
  parameter  int NUM_LEVELS = 4,
  parameter  int FIFO_DEPTH = 4,
  localparam int LVL_BITS   = lvl_bits(NUM_LEVELS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic [NUM_LEVELS-1:0]            in_valid,
  input  logic [NUM_LEVELS*COORD_BITS-1:0] in_x,
  input  logic [NUM_LEVELS*COORD_BITS-1:0] in_y,
  input  logic [NUM_LEVELS*SCORE_BITS-1:0] in_score,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [COORD_BITS-1:0]            out_x,
  output logic [COORD_BITS-1:0]            out_y,
  output logic [SCORE_BITS-1:0]            out_score,
  output logic [LVL_BITS-1:0]              out_level,
  output logic [NUM_LEVELS-1:0]            overflow,
  output logic [15:0]                      drop_count
);

  localparam int KP_W = 2*COORD_BITS + SCORE_BITS;

  logic [NUM_LEVELS-1:0] lane_push, lane_pop, lane_full, lane_empty, lane_drop;
  logic [KP_W-1:0]       lane_dout [NUM_LEVELS];
  logic [LVL_BITS-1:0]   last_grant, grant;
  logic                  any_ready, load;
  out_state_e            state_q, state_d;
  int                    idx;

  function automatic logic [15:0] sat_add16(input logic [15:0] base,
                                            input logic [NUM_LEVELS-1:0] drops);
    logic [16:0] s;
    s = {1'b0, base};
    for (int i = 0; i < NUM_LEVELS; i++) s = s + 17'(drops[i]);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  for (genvar i = 0; i < NUM_LEVELS; i++) begin : g_lane
    keypoint_fifo #(.W(KP_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (lane_push[i]),
      .pop   (lane_pop[i]),
      .din   ({in_x[i*COORD_BITS +: COORD_BITS], in_y[i*COORD_BITS +: COORD_BITS],
               in_score[i*SCORE_BITS +: SCORE_BITS]}),
      .dout  (lane_dout[i]),
      .full  (lane_full[i]),
      .empty (lane_empty[i])
    );
  end

  // Round-robin search starting one past the previously granted lane.
  always_comb begin
    grant     = last_grant;
    any_ready = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_LEVELS; k++) begin
      idx = (int'(last_grant) + 1 + k) % NUM_LEVELS;
      if (!any_ready && !lane_empty[idx]) begin
        grant     = LVL_BITS'(idx);
        any_ready = 1'b1;
      end
    end
  end

  assign load      = ((state_q == OUT_EMPTY) || out_ready) && any_ready;
  assign lane_push = in_valid & (~lane_full | lane_pop);
  assign lane_drop = in_valid & ~lane_push;
  assign out_valid = (state_q == OUT_HELD);

  always_comb begin
    lane_pop = '0;
    if (load) lane_pop[grant] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    if (load)                                  state_d = OUT_HELD;
    else if (state_q == OUT_HELD && out_ready) state_d = OUT_EMPTY;
  end

  // Output register stage: single held keypoint toward downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= OUT_EMPTY;
      last_grant <= LVL_BITS'(NUM_LEVELS - 1);
      out_x      <= '0;
      out_y      <= '0;
      out_score  <= '0;
      out_level  <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        last_grant                  <= grant;
        out_level                   <= grant;
        {out_x, out_y, out_score}   <= lane_dout[grant];
      end
    end
  end

  // A drop coinciding with clear is kept, so clear only zeroes the prior value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow   <= '0;
      drop_count <= '0;
    end else begin
      overflow   <= (clear ? '0 : overflow) | lane_drop;
      drop_count <= sat_add16(clear ? 16'd0 : drop_count, lane_drop);
    end
  end

endmodule

// File: tb/tb_keypoint_merger.sv
// Randomised and directed bench for keypoint_merger with a queue-based reference
// model feeding a scoreboard that a negedge monitor drains.
module tb_keypoint_merger;

  localparam int NL = 4;
  localparam int CB = 16;
  localparam int SB = 8;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            clear = 1'b0;
  logic [NL-1:0]   in_valid = '0;
  logic [NL*CB-1:0] in_x = '0;
  logic [NL*CB-1:0] in_y = '0;
  logic [NL*SB-1:0] in_score = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [CB-1:0]   out_x, out_y;
  logic [SB-1:0]   out_score;
  logic [1:0]      out_level;
  logic [NL-1:0]   overflow;
  logic [15:0]     drop_count;

  keypoint_merger #(.COORD_BITS(CB), .SCORE_BITS(SB), .NUM_LEVELS(NL), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
    .in_score(in_score), .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x),
    .out_y(out_y), .out_score(out_score), .out_level(out_level), .overflow(overflow),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  s;
    int          lvl;
  } kp_t;

  kp_t         lq [NL][$];
  kp_t         exp_q [$];
  bit          m_held;
  int          m_lg;
  logic [3:0]  m_ovf;
  int          m_dc;
  bit          e_valid;
  logic [3:0]  e_ovf;
  int          e_dc;
  int          total, bad, beats, b0;
  bit          checking;
  logic [15:0] fx, fy;
  logic [7:0]  fs;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < NL; l++) lq[l].delete();
    exp_q.delete();
    m_held = 0; m_lg = NL - 1; m_ovf = '0; m_dc = 0;
    e_valid = 0; e_ovf = '0; e_dc = 0;
  endtask

  // Behaviour for the coming edge, given the inputs just applied.
  task automatic model_step();
    bit  any, found;
    int  nd, g;
    kp_t it;
    any = 0; found = 0; nd = 0;
    for (int l = 0; l < NL; l++) if (lq[l].size() > 0) any = 1;
    if ((!m_held || out_ready) && any) begin
      for (int k = 1; k <= NL; k++) begin
        g = (m_lg + k) % NL;
        if (!found && lq[g].size() > 0) begin
          it = lq[g].pop_front();
          m_lg = g;
          found = 1;
        end
      end
      m_held = 1;
      exp_q.push_back(it);
    end else if (m_held && out_ready) begin
      m_held = 0;
    end
    if (clear) begin m_ovf = '0; m_dc = 0; end
    for (int l = 0; l < NL; l++) begin
      if (in_valid[l]) begin
        if (lq[l].size() < DEPTH) begin
          it.x = in_x[l*CB +: CB]; it.y = in_y[l*CB +: CB]; it.s = in_score[l*SB +: SB];
          it.lvl = l;
          lq[l].push_back(it);
        end else begin
          nd++;
          m_ovf[l] = 1'b1;
        end
      end
    end
    m_dc = (m_dc + nd > 65535) ? 65535 : m_dc + nd;
  endtask

  task automatic drive(input logic [3:0] iv, input logic rdy, input logic clr, input bit rnd);
    @(posedge clk); #1;
    e_valid = m_held; e_ovf = m_ovf; e_dc = m_dc;
    for (int l = 0; l < NL; l++) begin
      in_x[l*CB +: CB]     = rnd ? 16'($urandom) : fx;
      in_y[l*CB +: CB]     = rnd ? 16'($urandom) : fy;
      in_score[l*SB +: SB] = rnd ? 8'($urandom) : fs;
    end
    in_valid = iv; out_ready = rdy; clear = clr;
    model_step();
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = '0; out_ready = 1'b0; clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_x", out_x, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_out_score", out_score, 0);
    chk("rst_out_level", out_level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_count", drop_count, 0);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (checking && !rst) begin
      chk("out_valid", out_valid, e_valid);
      chk("overflow", overflow, e_ovf);
      chk("drop_count", drop_count, e_dc);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_beat: got level %0d expected no output", out_level);
        end else begin
          chk("out_x", out_x, exp_q[0].x);
          chk("out_y", out_y, exp_q[0].y);
          chk("out_score", out_score, exp_q[0].s);
          chk("out_level", out_level, exp_q[0].lvl);
          if (out_ready) begin
            void'(exp_q.pop_front());
            beats++;
          end
        end
      end
    end
  end

  initial begin
    total = 0; bad = 0; beats = 0; checking = 0;
    fx = 16'd100; fy = 16'd50; fs = 8'd7;
    do_reset();
    checking = 1;

    // single lane-2 keypoint
    b0 = beats;
    drive(4'b0100, 1, 0, 0);
    repeat (4) drive(4'b0000, 1, 0, 1);
    chk("single_beats", beats - b0, 1);

    // all lanes at once, fresh priority
    do_reset();
    b0 = beats;
    drive(4'b1111, 1, 0, 1);
    repeat (6) drive(4'b0000, 1, 0, 1);
    chk("all_lanes_beats", beats - b0, 4);

    // lane 1 overruns while output is stalled
    do_reset();
    repeat (6) drive(4'b0010, 0, 0, 1);
    drive(4'b0000, 0, 0, 1);
    chk("stall_overflow", overflow, 4'b0010);
    chk("stall_drop_count", drop_count, 1);
    repeat (8) drive(4'b0000, 1, 0, 1);

    // full lane 0 popped and pushed in the same cycle
    do_reset();
    repeat (5) drive(4'b0001, 0, 0, 1);
    drive(4'b0001, 1, 0, 1);
    drive(4'b0000, 0, 0, 1);
    chk("full_pushpop_drops", drop_count, 0);
    repeat (8) drive(4'b0000, 1, 0, 1);

    // reset while holding with three buffered
    do_reset();
    repeat (4) drive(4'b0001, 0, 0, 1);
    drive(4'b0000, 0, 0, 1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    model_reset();
    in_valid = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    b0 = beats;
    repeat (10) drive(4'b0000, 1, 0, 1);
    chk("post_rst_beats", beats - b0, 0);

    // drop counter saturation and clear
    do_reset();
    repeat (16400) drive(4'b1111, 0, 0, 1);
    drive(4'b0000, 0, 0, 1);
    chk("sat_drop_count", drop_count, 16'hFFFF);
    drive(4'b1111, 0, 1, 1);
    drive(4'b0000, 0, 1, 1);
    drive(4'b0000, 0, 0, 1);
    chk("clear_drop_count", drop_count, 0);
    chk("clear_overflow", overflow, 0);
    repeat (8) drive(4'b0000, 1, 0, 1);

    // random traffic
    do_reset();
    repeat (3000) begin
      drive(4'($urandom & $urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0), 1);
    end
    repeat (30) drive(4'b0000, 1, 0, 1);
    chk("leftover_expected", exp_q.size(), 0);

    checking = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
